// File: rtl/wave_shaper_if.sv
// Sample bus for wave_shaper: phase and shaping requests in, shaped samples out.
// The master drives requests; the slave (the shaper) returns the shaped sample.
interface wave_shaper_if #(
  parameter int W = 16
);
  logic         LOCKED;
  logic [W-1:0] PHASE;
  logic         IN_VALID;
  logic [1:0]   MODE;
  logic [W-1:0] PW;
  logic         INV;
  logic [W-1:0] OUT;
  logic         OUT_VALID;
  logic         SYNC;

  modport master (
    output LOCKED, PHASE, IN_VALID, MODE, PW, INV,
    input  OUT, OUT_VALID, SYNC
  );

  modport slave (
    input  LOCKED, PHASE, IN_VALID, MODE, PW, INV,
    output OUT, OUT_VALID, SYNC
  );
endinterface

// File: rtl/wave_shaper.sv
// Two-stage waveform shaper: turns a sawtooth phase into saw/triangle/square/pulse.
// Waveform settings are latched only at period wraps so changes never glitch mid-period.
module wave_shaper #(
  parameter int W         = 16,
  parameter bit PIPE_HOLD = 1'b1
) (
  input logic          CLK,
  input logic          RST_N,
  wave_shaper_if.slave bus
);
  localparam logic [W-1:0] MID = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] QTR = {2'b01, {(W-2){1'b0}}};

  logic [W-1:0] prev_phase_q, prev_phase_d;
  logic         first_q, first_d;
  logic [1:0]   act_mode_q, act_mode_d;
  logic [W-1:0] act_pw_q, act_pw_d;
  logic         act_inv_q, act_inv_d;

  logic         s1_valid_q, s1_valid_d;
  logic         s1_sync_q, s1_sync_d;
  logic [W-1:0] s1_phase_q, s1_phase_d;
  logic [1:0]   s1_mode_q, s1_mode_d;
  logic [W-1:0] s1_pw_q, s1_pw_d;
  logic         s1_inv_q, s1_inv_d;

  logic [W-1:0] out_q, out_d;
  logic         out_valid_q, out_valid_d;
  logic         sync_q, sync_d;

  logic         accept;
  logic         wrap;
  logic [W-1:0] tri_sum;
  logic [W-1:0] tri_lin;
  logic [W-1:0] tri_val;
  logic [W-1:0] sel_val;

  assign accept = bus.LOCKED & bus.IN_VALID;
  assign wrap   = accept & (first_q | (bus.PHASE < prev_phase_q));

  // Stage 1: on a wrap the fresh request shapes this very sample.
  always_comb begin
    prev_phase_d = prev_phase_q;
    first_d      = first_q;
    act_mode_d   = act_mode_q;
    act_pw_d     = act_pw_q;
    act_inv_d    = act_inv_q;
    if (accept) begin
      prev_phase_d = bus.PHASE;
      first_d      = 1'b0;
    end
    if (wrap) begin
      act_mode_d = bus.MODE;
      act_pw_d   = bus.PW;
      act_inv_d  = bus.INV;
    end
    s1_valid_d = accept;
    s1_sync_d  = wrap;
    s1_phase_d = bus.PHASE;
    s1_mode_d  = act_mode_d;
    s1_pw_d    = act_pw_d;
    s1_inv_d   = act_inv_d;
  end

  always_comb begin
    tri_sum = s1_phase_q + QTR;
    tri_lin = {tri_sum[W-2:0], 1'b0};
    tri_val = tri_sum[W-1] ? ~tri_lin : tri_lin;
    case (s1_mode_q)
      2'd0:    sel_val = s1_phase_q;
      2'd1:    sel_val = tri_val;
      2'd2:    sel_val = (s1_phase_q < MID) ? '1 : '0;
      default: sel_val = (s1_phase_q < s1_pw_q) ? '1 : '0;
    endcase
    if (s1_valid_q)
      out_d = s1_inv_q ? ~sel_val : sel_val;
    else
      out_d = PIPE_HOLD ? out_q : MID;
    out_valid_d = s1_valid_q;
    sync_d      = s1_valid_q & s1_sync_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      prev_phase_q <= '0;
      first_q      <= 1'b1;
      act_mode_q   <= 2'd0;
      act_pw_q     <= MID;
      act_inv_q    <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_sync_q    <= 1'b0;
      s1_phase_q   <= '0;
      s1_mode_q    <= 2'd0;
      s1_pw_q      <= MID;
      s1_inv_q     <= 1'b0;
      out_q        <= MID;
      out_valid_q  <= 1'b0;
      sync_q       <= 1'b0;
    end else begin
      prev_phase_q <= prev_phase_d;
      first_q      <= first_d;
      act_mode_q   <= act_mode_d;
      act_pw_q     <= act_pw_d;
      act_inv_q    <= act_inv_d;
      s1_valid_q   <= s1_valid_d;
      s1_sync_q    <= s1_sync_d;
      s1_phase_q   <= s1_phase_d;
      s1_mode_q    <= s1_mode_d;
      s1_pw_q      <= s1_pw_d;
      s1_inv_q     <= s1_inv_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      sync_q       <= sync_d;
    end
  end

  assign bus.OUT       = out_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.SYNC      = sync_q;
endmodule

// File: tb/tb_wave_shaper.sv
// Directed bench for wave_shaper (W=16, PIPE_HOLD=1) with hand-computed expectations.
module tb_wave_shaper;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  wave_shaper_if #(.W(16)) bus ();

  wave_shaper #(.W(16), .PIPE_HOLD(1'b1)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [15:0] ph, input logic [1:0] md,
                       input logic [15:0] pw, input logic inv);
    bus.IN_VALID = iv;
    bus.PHASE    = ph;
    bus.MODE     = md;
    bus.PW       = pw;
    bus.INV      = inv;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.LOCKED = 1'b1;
    drive(1'b1, 16'h1234, 2'd0, 16'h0000, 1'b1);
    step();
    step();
    n_checks++;
    if ({bus.OUT_VALID, bus.SYNC, bus.OUT} !== {1'b0, 1'b0, 16'h8000}) begin
      n_fail++;
      $display("FAIL reset_hold: got v=%0b s=%0b out=%h, want v=0 s=0 out=8000",
               bus.OUT_VALID, bus.SYNC, bus.OUT);
    end
    drive(1'b0, 16'h0000, 2'd0, 16'h0000, 1'b0);
    rst_n = 1'b1;
    step();
    step();
    n_checks++;
    if ({bus.OUT_VALID, bus.SYNC, bus.OUT} !== {1'b0, 1'b0, 16'h8000}) begin
      n_fail++;
      $display("FAIL reset_idle: got v=%0b s=%0b out=%h, want v=0 s=0 out=8000",
               bus.OUT_VALID, bus.SYNC, bus.OUT);
    end
  endtask

  task automatic test_triangle();
    logic [15:0] ph [0:3];
    logic [15:0] ex [0:3];
    logic        sy [0:3];
    ph = '{16'h0000, 16'h4000, 16'hC000, 16'h3FFF};
    ex = '{16'h8000, 16'hFFFF, 16'h0000, 16'hFFFE};
    sy = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) drive(1'b1, ph[i], 2'd1, 16'h0000, 1'b0);
      else       drive(1'b0, 16'h0000, 2'd0, 16'h0000, 1'b0);
      step();
      if (i > 0) begin
        n_checks++;
        if ({bus.OUT_VALID, bus.SYNC, bus.OUT} !== {1'b1, sy[i-1], ex[i-1]}) begin
          n_fail++;
          $display("FAIL triangle[%0d]: got v=%0b s=%0b out=%h, want v=1 s=%0b out=%h",
                   i-1, bus.OUT_VALID, bus.SYNC, bus.OUT, sy[i-1], ex[i-1]);
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    logic [15:0] ph [0:5];
    logic [1:0]  md [0:5];
    logic [15:0] ex [0:5];
    logic        sy [0:5];
    ph = '{16'h0000, 16'h8000, 16'hFFF0, 16'h0010, 16'h7FFF, 16'h8000};
    md = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    ex = '{16'h0000, 16'h8000, 16'hFFF0, 16'hFFFF, 16'hFFFF, 16'h0000};
    sy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) drive(1'b1, ph[i], md[i], 16'h0000, 1'b0);
      else       drive(1'b0, 16'h0000, 2'd0, 16'h0000, 1'b0);
      step();
      if (i > 0) begin
        n_checks++;
        if ({bus.OUT_VALID, bus.SYNC, bus.OUT} !== {1'b1, sy[i-1], ex[i-1]}) begin
          n_fail++;
          $display("FAIL mode_switch[%0d]: got v=%0b s=%0b out=%h, want v=1 s=%0b out=%h",
                   i-1, bus.OUT_VALID, bus.SYNC, bus.OUT, sy[i-1], ex[i-1]);
        end
      end
    end
  endtask

  task automatic test_pulse();
    logic [15:0] ph [0:8];
    logic [15:0] pw [0:8];
    logic        iv [0:8];
    logic [15:0] ex [0:8];
    logic        sy [0:8];
    ph = '{16'h0000, 16'h1FFF, 16'h2000, 16'h1000, 16'h1800, 16'h0100, 16'h0200, 16'h0000, 16'hFFFF};
    pw = '{16'h2000, 16'h2000, 16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h2000, 16'hFFFF, 16'h0000};
    iv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ex = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
    sy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i <= 9; i++) begin
      if (i < 9) drive(1'b1, ph[i], 2'd3, pw[i], iv[i]);
      else       drive(1'b0, 16'h0000, 2'd0, 16'h0000, 1'b0);
      step();
      if (i > 0) begin
        n_checks++;
        if ({bus.OUT_VALID, bus.SYNC, bus.OUT} !== {1'b1, sy[i-1], ex[i-1]}) begin
          n_fail++;
          $display("FAIL pulse[%0d]: got v=%0b s=%0b out=%h, want v=1 s=%0b out=%h",
                   i-1, bus.OUT_VALID, bus.SYNC, bus.OUT, sy[i-1], ex[i-1]);
        end
      end
    end
  endtask

  task automatic test_gap();
    logic [15:0] ph [0:2];
    logic        vi [0:2];
    logic [15:0] ex [0:2];
    logic        sy [0:2];
    ph = '{16'h0100, 16'h0200, 16'h0300};
    vi = '{1'b1, 1'b0, 1'b1};
    ex = '{16'h0100, 16'h0100, 16'h0300};
    sy = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i <= 3; i++) begin
      if (i < 3) drive(vi[i], ph[i], 2'd0, 16'h0000, 1'b0);
      else       drive(1'b0, 16'h0000, 2'd0, 16'h0000, 1'b0);
      step();
      if (i > 0) begin
        n_checks++;
        if ({bus.OUT_VALID, bus.SYNC, bus.OUT} !== {vi[i-1], sy[i-1], ex[i-1]}) begin
          n_fail++;
          $display("FAIL gap[%0d]: got v=%0b s=%0b out=%h, want v=%0b s=%0b out=%h",
                   i-1, bus.OUT_VALID, bus.SYNC, bus.OUT, vi[i-1], sy[i-1], ex[i-1]);
        end
      end
    end
  endtask

  task automatic test_locked();
    logic [15:0] ph [0:5];
    logic [1:0]  md [0:5];
    logic        lk [0:5];
    logic [15:0] ex [0:5];
    logic        sy [0:5];
    ph = '{16'h0400, 16'h0500, 16'h0000, 16'h0000, 16'h0000, 16'h0350};
    md = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0};
    lk = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    ex = '{16'h0400, 16'h0500, 16'h0500, 16'h0500, 16'h0500, 16'h0350};
    sy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        bus.LOCKED = lk[i];
        drive(1'b1, ph[i], md[i], 16'h0000, 1'b0);
      end else begin
        bus.LOCKED = 1'b1;
        drive(1'b0, 16'h0000, 2'd0, 16'h0000, 1'b0);
      end
      step();
      if (i > 0) begin
        n_checks++;
        if ({bus.OUT_VALID, bus.SYNC, bus.OUT} !== {lk[i-1], sy[i-1], ex[i-1]}) begin
          n_fail++;
          $display("FAIL locked[%0d]: got v=%0b s=%0b out=%h, want v=%0b s=%0b out=%h",
                   i-1, bus.OUT_VALID, bus.SYNC, bus.OUT, lk[i-1], sy[i-1], ex[i-1]);
        end
      end
    end
  endtask

  task automatic test_reset_in_flight();
    drive(1'b1, 16'h0600, 2'd0, 16'h0000, 1'b0);
    step();
    drive(1'b1, 16'h0700, 2'd0, 16'h0000, 1'b0);
    rst_n = 1'b0;
    step();
    n_checks++;
    if ({bus.OUT_VALID, bus.SYNC, bus.OUT} !== {1'b0, 1'b0, 16'h8000}) begin
      n_fail++;
      $display("FAIL flight_rst: got v=%0b s=%0b out=%h, want v=0 s=0 out=8000",
               bus.OUT_VALID, bus.SYNC, bus.OUT);
    end
    rst_n = 1'b1;
    drive(1'b0, 16'h0000, 2'd0, 16'h0000, 1'b0);
    step();
    n_checks++;
    if ({bus.OUT_VALID, bus.SYNC, bus.OUT} !== {1'b0, 1'b0, 16'h8000}) begin
      n_fail++;
      $display("FAIL flight_drain: got v=%0b s=%0b out=%h, want v=0 s=0 out=8000",
               bus.OUT_VALID, bus.SYNC, bus.OUT);
    end
    drive(1'b1, 16'h0800, 2'd0, 16'h0000, 1'b0);
    step();
    drive(1'b0, 16'h0000, 2'd0, 16'h0000, 1'b0);
    step();
    n_checks++;
    if ({bus.OUT_VALID, bus.SYNC, bus.OUT} !== {1'b1, 1'b1, 16'h0800}) begin
      n_fail++;
      $display("FAIL flight_first: got v=%0b s=%0b out=%h, want v=1 s=1 out=0800",
               bus.OUT_VALID, bus.SYNC, bus.OUT);
    end
  endtask

  initial begin
    test_reset();
    test_triangle();
    test_mode_switch();
    test_pulse();
    test_gap();
    test_locked();
    test_reset_in_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
